// File: rtl/pj_pkg.sv
// Shared definitions for the MindFocus N-button datapath: target-generator
// states, default LFSR taps / play timeout, and the index-width helper.
package pj_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    GERANDO = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  localparam logic [15:0] TAPS_PADRAO    = 16'hB400;
  localparam int unsigned TIMEOUT_PADRAO = 50000;
  localparam int unsigned MAX_TENTATIVAS = 8;

  // Bits needed to index n targets, never less than one.
  function automatic int unsigned largura_indice(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gerador_alvo.sv
// One-hot target generator: free-running seed counter, Galois LFSR and the
// OCIOSO/GERANDO/PRONTO handshake. Optional macro ALVO_SEM_REPETICAO_EN
// forbids repeating the current target, with a bounded retry count.
module gerador_alvo
  import pj_pkg::*;
#(
  parameter int unsigned       N_BOTOES = 4,
  parameter int unsigned       W_LFSR   = 16,
  parameter logic [W_LFSR-1:0] TAPS     = W_LFSR'(TAPS_PADRAO)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_captura_semente,
  input  logic                i_gera_alvo,
  output logic                o_alvo_pronto,
  output logic [N_BOTOES-1:0] o_alvo,
  output logic [W_LFSR-1:0]   o_db_lfsr
);

  localparam int unsigned IW = largura_indice(N_BOTOES);

  estado_t             r_estado, w_estado_prox;
  logic [W_LFSR-1:0]   r_semente;
  logic [W_LFSR-1:0]   r_lfsr;
  logic [W_LFSR-1:0]   w_lfsr_prox;
  logic [N_BOTOES-1:0] r_alvo;
  logic [IW-1:0]       w_indice;
  logic [IW-1:0]       w_sel;
  logic                w_dentro;
  logic                w_aceita;

  assign w_lfsr_prox = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_indice    = w_lfsr_prox[W_LFSR-1 -: IW];
  assign w_dentro    = (32'(w_indice) < N_BOTOES);

`ifdef ALVO_SEM_REPETICAO_EN
  localparam int unsigned TW = $clog2(MAX_TENTATIVAS + 1);

  logic [TW-1:0] r_tentativas;
  logic [IW-1:0] r_indice;
  logic          w_repetido;
  logic          w_forcado;
  logic [IW-1:0] w_indice_forcado;

  assign w_repetido       = (r_alvo != '0) && (w_indice == r_indice);
  assign w_forcado        = (r_tentativas == TW'(MAX_TENTATIVAS));
  assign w_indice_forcado = (r_indice == IW'(N_BOTOES - 1)) ? '0 : r_indice + 1'b1;
  assign w_aceita         = w_forcado | (w_dentro & ~w_repetido);
  assign w_sel            = w_forcado ? w_indice_forcado : w_indice;

  // Consecutive-rejection counter and index of the current target.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tentativas <= '0;
      r_indice     <= '0;
    end else if (r_estado == GERANDO) begin
      if (w_aceita) begin
        r_tentativas <= '0;
        r_indice     <= w_sel;
      end else begin
        r_tentativas <= r_tentativas + 1'b1;
      end
    end else begin
      r_tentativas <= '0;
    end
  end
`else
  assign w_aceita = w_dentro;
  assign w_sel    = w_indice;
`endif

  // Seed counter runs every cycle so the captured seed depends on timing.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_semente <= W_LFSR'(1);
    else         r_semente <= r_semente + 1'b1;
  end

  // LFSR: seed capture wins over the per-cycle step while generating.
  always_ff @(posedge i_clock) begin
    if (i_reset)                   r_lfsr <= W_LFSR'(1);
    else if (i_captura_semente)    r_lfsr <= (r_semente == '0) ? W_LFSR'(1) : r_semente;
    else if (r_estado == GERANDO)  r_lfsr <= w_lfsr_prox;
  end

  // Target register loads the one-hot of the accepted candidate.
  always_ff @(posedge i_clock) begin
    if (i_reset)                               r_alvo <= '0;
    else if ((r_estado == GERANDO) && w_aceita) r_alvo <= {{(N_BOTOES-1){1'b0}}, 1'b1} << w_sel;
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_estado <= OCIOSO;
    else         r_estado <= w_estado_prox;
  end

  // Next state; a request while PRONTO goes straight to GERANDO so the new
  // target arrives with the same latency as from OCIOSO.
  always_comb begin
    w_estado_prox = r_estado;
    unique case (r_estado)
      OCIOSO:  if (i_gera_alvo) w_estado_prox = GERANDO;
      GERANDO: if (w_aceita)    w_estado_prox = PRONTO;
      PRONTO:  if (i_gera_alvo) w_estado_prox = GERANDO;
      default: w_estado_prox = OCIOSO;
    endcase
  end

  assign o_alvo_pronto = (r_estado == PRONTO);
  assign o_alvo        = r_alvo;
  assign o_db_lfsr     = r_lfsr;

endmodule

// File: rtl/fluxo_dados_n.sv
// MindFocus N-button datapath: target generator, play edge detector, play
// register, hit/round counters and play timer. Optional feature selected by
// macro ALVO_SEM_REPETICAO_EN (inside gerador_alvo).
module fluxo_dados_n
  import pj_pkg::*;
#(
  parameter int unsigned       N_BOTOES  = 4,
  parameter int unsigned       N_RODADAS = 3,
  parameter int unsigned       W_CONT    = 4,
  parameter int unsigned       W_LFSR    = 16,
  parameter logic [W_LFSR-1:0] TAPS      = W_LFSR'(TAPS_PADRAO),
  parameter int unsigned       TIMEOUT   = TIMEOUT_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                zeraA,
  input  logic                zeraRod,
  input  logic                zeraR,
  input  logic                contaA,
  input  logic                contaRod,
  input  logic                registraR,
  input  logic                captura_semente,
  input  logic                gera_alvo,
  input  logic                inicia_tempo,
  output logic                jogada_feita,
  output logic                alvo_pronto,
  output logic                acerto,
  output logic                rodadaIgualFinal,
  output logic                timeout,
  output logic [W_CONT-1:0]   acertos,
  output logic [W_CONT-1:0]   rodada,
  output logic [N_BOTOES-1:0] alvo,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic [W_LFSR-1:0]   db_lfsr
);

  localparam int unsigned TW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  logic                r_bot_atual, r_bot_ant;
  logic [N_BOTOES-1:0] r_jogada;
  logic [W_CONT-1:0]   r_acertos, r_rodada;
  logic [TW-1:0]       r_tempo;
  logic                r_armado, r_timeout;
  logic                w_jogada_feita;
  logic [N_BOTOES-1:0] w_alvo;

  gerador_alvo #(
    .N_BOTOES (N_BOTOES),
    .W_LFSR   (W_LFSR),
    .TAPS     (TAPS)
  ) u_gerador (
    .i_clock           (clock),
    .i_reset           (reset),
    .i_captura_semente (captura_semente),
    .i_gera_alvo       (gera_alvo),
    .o_alvo_pronto     (alvo_pronto),
    .o_alvo            (w_alvo),
    .o_db_lfsr         (db_lfsr)
  );

  // Any-button edge detector; zeraRod also clears it.
  always_ff @(posedge clock) begin
    if (reset || zeraRod) begin
      r_bot_atual <= 1'b0;
      r_bot_ant   <= 1'b0;
    end else begin
      r_bot_atual <= |botoes;
      r_bot_ant   <= r_bot_atual;
    end
  end

  assign w_jogada_feita = r_bot_atual & ~r_bot_ant;

  // Play register.
  always_ff @(posedge clock) begin
    if (reset || zeraR) r_jogada <= '0;
    else if (registraR) r_jogada <= botoes;
  end

  // Hit counter saturates at all-ones.
  always_ff @(posedge clock) begin
    if (reset || zeraA)                    r_acertos <= '0;
    else if (contaA && (r_acertos != '1)) r_acertos <= r_acertos + 1'b1;
  end

  // Round counter wraps naturally.
  always_ff @(posedge clock) begin
    if (reset || zeraRod) r_rodada <= '0;
    else if (contaRod)    r_rodada <= r_rodada + 1'b1;
  end

  // Play timer: restart wins over a simultaneous play; timeout latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tempo   <= '0;
      r_armado  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (inicia_tempo) begin
      r_tempo   <= '0;
      r_armado  <= 1'b1;
      r_timeout <= 1'b0;
    end else if (r_armado) begin
      if (w_jogada_feita) begin
        r_armado <= 1'b0;
      end else begin
        r_tempo <= r_tempo + 1'b1;
        if (r_tempo == TW'(TIMEOUT - 2)) begin
          r_armado  <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign jogada_feita     = w_jogada_feita;
  assign acerto           = (r_jogada == w_alvo) && (w_alvo != '0);
  assign rodadaIgualFinal = (r_rodada == W_CONT'(N_RODADAS));
  assign timeout          = r_timeout;
  assign acertos          = r_acertos;
  assign rodada           = r_rodada;
  assign alvo             = w_alvo;
  assign db_jogada        = r_jogada;

endmodule

// File: tb/tb_fluxo_dados_n.sv
// Randomised self-checking bench for fluxo_dados_n: a 4-button and a
// 3-button instance run side by side against a behavioural model.
module tb_fluxo_dados_n;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       zeraA, zeraRod, zeraR, contaA, contaRod, registraR;
  logic       captura, gera, inicia;

  logic       jf4, pronto4, acerto4, rfim4, to4;
  logic [3:0] acertos4, rodada4, alvo4, dbj4;
  logic [15:0] lfsr4;
  logic       jf3, pronto3, acerto3, rfim3, to3;
  logic [3:0] acertos3, rodada3;
  logic [2:0] alvo3, dbj3;
  logic [15:0] lfsr3;

  int n_comparados  = 0;
  int n_divergentes = 0;

  logic [15:0] m_semente;
  logic [15:0] m_q4, m_q3;
  logic [3:0]  m_alvo4;
  logic [2:0]  m_alvo3;

  always #5 clk = ~clk;

  fluxo_dados_n #(.N_BOTOES(4), .TIMEOUT(TO)) dut4 (
    .clock(clk), .reset(reset), .botoes(botoes),
    .zeraA(zeraA), .zeraRod(zeraRod), .zeraR(zeraR),
    .contaA(contaA), .contaRod(contaRod), .registraR(registraR),
    .captura_semente(captura), .gera_alvo(gera), .inicia_tempo(inicia),
    .jogada_feita(jf4), .alvo_pronto(pronto4), .acerto(acerto4),
    .rodadaIgualFinal(rfim4), .timeout(to4), .acertos(acertos4),
    .rodada(rodada4), .alvo(alvo4), .db_jogada(dbj4), .db_lfsr(lfsr4)
  );

  fluxo_dados_n #(.N_BOTOES(3), .TIMEOUT(TO)) dut3 (
    .clock(clk), .reset(reset), .botoes(botoes[2:0]),
    .zeraA(zeraA), .zeraRod(zeraRod), .zeraR(zeraR),
    .contaA(contaA), .contaRod(contaRod), .registraR(registraR),
    .captura_semente(captura), .gera_alvo(gera), .inicia_tempo(inicia),
    .jogada_feita(jf3), .alvo_pronto(pronto3), .acerto(acerto3),
    .rodadaIgualFinal(rfim3), .timeout(to3), .acertos(acertos3),
    .rodada(rodada3), .alvo(alvo3), .db_jogada(dbj3), .db_lfsr(lfsr3)
  );

  // Expected seed counter: 1 after reset, +1 every cycle.
  always @(posedge clk) begin
    if (reset) m_semente <= 16'd1;
    else       m_semente <= m_semente + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comparados++;
    if (obs !== esp) begin
      n_divergentes++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] passo(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Steps the model LFSR until the top two bits form an index below n.
  task automatic modelo_gera(input logic [15:0] q0, input int n,
                             output logic [15:0] qf, output int idx, output int passos);
    qf = q0;
    passos = 0;
    do begin
      qf = passo(qf);
      passos++;
      idx = int'(qf[15:14]);
    end while (idx >= n);
  endtask

  task automatic gera_e_confere();
    logic [15:0] q4, q3;
    int idx4, idx3, p4, p3, lat4, lat3;
    modelo_gera(m_q4, 4, q4, idx4, p4);
    modelo_gera(m_q3, 3, q3, idx3, p3);
    gera = 1'b1;
    tick();
    gera = 1'b0;
    chk("pronto4_gerando", pronto4, 0);
    chk("pronto3_gerando", pronto3, 0);
    lat4 = 0;
    lat3 = 0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (lat4 == 0 && pronto4) lat4 = c;
      if (lat3 == 0 && pronto3) lat3 = c;
      if (lat4 != 0 && lat3 != 0) break;
    end
    chk("latencia4", lat4, 1 + p4);
    chk("latencia3", lat3, 1 + p3);
    m_q4 = q4;
    m_q3 = q3;
    m_alvo4 = 4'b0001 << idx4;
    m_alvo3 = 3'b001 << idx3;
    chk("alvo4", alvo4, m_alvo4);
    chk("lfsr4", lfsr4, m_q4);
    chk("alvo3", alvo3, m_alvo3);
    chk("lfsr3", lfsr3, m_q3);
  endtask

  task automatic jogada(input logic [3:0] b);
    botoes = b;
    registraR = 1'b1;
    tick();
    registraR = 1'b0;
    chk("db_jogada4", dbj4, b);
    chk("db_jogada3", dbj3, b[2:0]);
    chk("acerto4", acerto4, (b == m_alvo4) && (m_alvo4 != 0));
    chk("acerto3", acerto3, (b[2:0] == m_alvo3) && (m_alvo3 != 0));
    botoes = '0;
    tick();
    tick();
  endtask

  // Arm the timer, press after k cycles (k < 0: never) and check the level.
  task automatic teste_tempo(input int k);
    logic esp;
    botoes = '0;
    tick(); tick(); tick();
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == k) botoes = 4'b0001;
      tick();
    end
    esp = (k < 0) || (k >= TO - 2);
    chk("timeout4_press", to4, esp);
    chk("timeout3_press", to3, esp);
    botoes = '0;
  endtask

  task automatic espera_timeout(input string tag);
    for (int i = 0; i < TO - 2; i++) tick();
    chk({tag, "_antes"}, to4, 0);
    tick();
    chk({tag, "_sobe"}, to4, 1);
    chk({tag, "_sobe3"}, to3, 1);
  endtask

  initial begin
    int pulsos4, pulsos3, m_ac, m_rod;
    logic [3:0] b;
    logic [15:0] sem;

    reset = 1'b1; botoes = '0;
    zeraA = 0; zeraRod = 0; zeraR = 0; contaA = 0; contaRod = 0; registraR = 0;
    captura = 0; gera = 0; inicia = 0;
    tick(); tick(); tick();
    reset = 1'b0;
    m_q4 = 16'd1; m_q3 = 16'd1; m_alvo4 = '0; m_alvo3 = '0;

    chk("rst_alvo", alvo4, 0);
    chk("rst_pronto", pronto4, 0);
    chk("rst_lfsr", lfsr4, 1);
    chk("rst_acertos", acertos4, 0);
    chk("rst_rodada", rodada4, 0);
    chk("rst_timeout", to4, 0);
    chk("rst_jogada", jf4, 0);
    chk("rst_dbj", dbj4, 0);
    chk("rst_acerto", acerto4, 0);
    chk("rst_rfim", rfim4, 0);

    // First target from the reset seed: q = 0xB400, alvo = 0100.
    gera_e_confere();
    chk("alvo4_const", alvo4, 4'b0100);
    chk("lfsr4_const", lfsr4, 16'hB400);

    // Held button gives one pulse; register it for a hit.
    pulsos4 = 0; pulsos3 = 0;
    botoes = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) registraR = 1'b1;
      tick();
      registraR = 1'b0;
      pulsos4 += int'(jf4);
      pulsos3 += int'(jf3);
    end
    chk("pulsos4", pulsos4, 1);
    chk("pulsos3", pulsos3, 1);
    chk("acerto_hold", acerto4, 1);
    botoes = '0;
    tick(); tick();
    jogada(4'b0110);
    chk("acerto_multi", acerto4, 0);

    // zeraR has priority over registraR.
    botoes = 4'b0100; zeraR = 1'b1; registraR = 1'b1;
    tick();
    zeraR = 1'b0; registraR = 1'b0; botoes = '0;
    chk("zeraR_prio", dbj4, 0);
    tick(); tick();

    // Second target from PRONTO: q = 0x5A00, alvo = 0010.
    gera_e_confere();
    chk("alvo4_seg", alvo4, 4'b0010);

    for (int r = 0; r < 20; r++) gera_e_confere();

    // Seed capture from the running counter.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 9)) tick();
      sem = (m_semente == 16'd0) ? 16'd1 : m_semente;
      captura = 1'b1;
      tick();
      captura = 1'b0;
      chk("captura4", lfsr4, sem);
      chk("captura3", lfsr3, sem);
      m_q4 = sem; m_q3 = sem;
      for (int g = 0; g < 5; g++) gera_e_confere();
    end

    // Random plays against the current target.
    for (int r = 0; r < 12; r++) begin
      if (r % 3 == 0) gera_e_confere();
      b = ($urandom_range(0, 1) == 1) ? m_alvo4 : 4'($urandom);
      jogada(b);
    end

    // Timer: no press, then hold, then restart clears the level.
    botoes = '0; tick(); tick();
    inicia = 1'b1; tick(); inicia = 1'b0;
    espera_timeout("timeout_livre");
    repeat (5) tick();
    chk("timeout_mantem", to4, 1);
    inicia = 1'b1; tick(); inicia = 1'b0;
    chk("timeout_limpa", to4, 0);
    teste_tempo(5);
    teste_tempo(TO - 3);
    teste_tempo(TO - 2);
    teste_tempo(-1);
    for (int r = 0; r < 4; r++) teste_tempo(int'($urandom_range(10, 25)));

    // Restart in the same cycle as a play keeps the timer armed.
    botoes = '0; tick(); tick();
    inicia = 1'b1; tick(); inicia = 1'b0;
    botoes = 4'b0010; tick();
    inicia = 1'b1; tick(); inicia = 1'b0;
    espera_timeout("timeout_reinicia");
    botoes = '0;

    // Counters.
    zeraA = 1; zeraRod = 1; tick(); zeraA = 0; zeraRod = 0;
    contaRod = 1; repeat (3) tick(); contaRod = 0;
    chk("rodada_3", rodada4, 3);
    chk("rodada_final", rfim4, 1);
    contaA = 1; repeat (20) tick(); contaA = 0;
    chk("acertos_sat", acertos4, 15);
    m_ac = 15; m_rod = 3;
    for (int r = 0; r < 60; r++) begin
      zeraA = ($urandom_range(0, 7) == 0);
      zeraRod = ($urandom_range(0, 7) == 0);
      contaA = $urandom_range(0, 1);
      contaRod = $urandom_range(0, 1);
      if (zeraA) m_ac = 0; else if (contaA && m_ac < 15) m_ac++;
      if (zeraRod) m_rod = 0; else if (contaRod) m_rod = (m_rod + 1) % 16;
      tick();
      chk("acertos4", acertos4, m_ac);
      chk("rodada4", rodada4, m_rod);
      chk("rfim4", rfim4, m_rod == 3);
      chk("acertos3", acertos3, m_ac);
      chk("rfim3", rfim3, m_rod == 3);
    end
    zeraA = 0; zeraRod = 0; contaA = 0; contaRod = 0;

    // Reset while generating.
    gera = 1'b1; tick(); gera = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_gen_alvo4", alvo4, 0);
    chk("rst_gen_pronto4", pronto4, 0);
    chk("rst_gen_alvo3", alvo3, 0);
    chk("rst_gen_lfsr", lfsr4, 1);
    m_q4 = 16'd1; m_q3 = 16'd1;
    gera_e_confere();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_divergentes);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
